// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: physical register and data
// widths, functional-unit indices, opcodes and the station row layout.
package Types;

  localparam int PREG_W   = 6;
  localparam int WORD_W   = 32;
  localparam int FU_IDX_W = 2;

  typedef logic [PREG_W-1:0]   p_reg;
  typedef logic [WORD_W-1:0]   word;
  typedef logic [FU_IDX_W-1:0] fu_idx;

  localparam fu_idx FU_ALU0 = 2'd0;
  localparam fu_idx FU_ALU1 = 2'd1;
  localparam fu_idx FU_MEM  = 2'd2;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_LD  = 4'd4,
    OP_ST  = 4'd5
  } op_e;

  // One decoded, renamed operation together with its operand capture state.
  typedef struct packed {
    op_e   op;
    fu_idx fu;
    p_reg  dst;
    p_reg  src0_preg;
    logic  src0_ready;
    word   src0_data;
    p_reg  src1_preg;
    logic  src1_ready;
    word   src1_data;
  } rs_row_struct;

endpackage

// File: rtl/reservation_station_select.sv
// Per-FU issue picker: turns an eligibility vector into a one-hot grant.
// RS_OLDEST_FIRST_EN switches from lowest-index to oldest-first picking,
// using the age matrix kept by the station (older[j][e] = j older than e).
module rs_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            elig,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
  output logic [DEPTH-1:0]            grant
);

`ifdef RS_OLDEST_FIRST_EN
  logic blocked;

  // Grant the eligible entry that no other eligible entry is older than.
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != e && elig[j] && older[j][e]) blocked = 1'b1;
      end
      grant[e] = elig[e] && !blocked;
    end
  end
`else
  logic found;

  // Grant the lowest-indexed eligible entry.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (elig[e] && !found) begin
        grant[e] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reservation_station.sv
// Reservation station: accepts up to DISP_W renamed operations per cycle,
// snoops CDB_W completion channels for operands, and issues at most one
// ready operation per functional unit per cycle as a registered pulse.
// Optional macro RS_OLDEST_FIRST_EN enables oldest-first selection.
module reservation_station
  import Types::*;
#(
  parameter int DEPTH  = 16,
  parameter int DISP_W = 2,
  parameter int NUM_FU = 3,
  parameter int CDB_W  = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic [DISP_W-1:0]                i_disp_valid,
  input  rs_row_struct [DISP_W-1:0]        i_disp_row,
  output logic                             o_disp_ready,
  input  logic [CDB_W-1:0]                 i_cdb_valid,
  input  p_reg [CDB_W-1:0]                 i_cdb_preg,
  input  word [CDB_W-1:0]                  i_cdb_data,
  input  logic [NUM_FU-1:0]                i_fu_ready,
  output logic [NUM_FU-1:0]                o_issue_valid,
  output rs_row_struct [NUM_FU-1:0]        o_issue_row,
  output logic [$clog2(DEPTH):0]           o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rs_row_struct [DEPTH-1:0]          entries, entries_next;
  logic [DEPTH-1:0]                  in_use, in_use_next, issue_mask;
  logic [CW-1:0]                     count, count_next;
  logic [NUM_FU-1:0][DEPTH-1:0]      elig, grant;
  rs_row_struct [NUM_FU-1:0]         issue_sel;
  rs_row_struct [DISP_W-1:0]         disp_prep;
  logic [DISP_W-1:0]                 alloc_en;
  logic [DISP_W-1:0][IW-1:0]         alloc_idx;
  logic [DEPTH-1:0]                  taken;
  logic                              found;

`ifdef RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][DEPTH-1:0]       older, older_next;
`endif

  assign o_disp_ready = (count <= CW'(DEPTH - DISP_W));
  assign o_count      = count;

  // Incoming rows: sources become ready when flagged, when they name p0, or
  // when a completion for their register is broadcast in the same cycle.
  always_comb begin
    disp_prep = i_disp_row;
    for (int k = 0; k < DISP_W; k++) begin
      if (i_disp_row[k].src0_preg == '0) disp_prep[k].src0_ready = 1'b1;
      if (i_disp_row[k].src1_preg == '0) disp_prep[k].src1_ready = 1'b1;
      for (int c = 0; c < CDB_W; c++) begin
        if (i_cdb_valid[c] && i_cdb_preg[c] != '0) begin
          if (i_disp_row[k].src0_preg == i_cdb_preg[c]) begin
            disp_prep[k].src0_ready = 1'b1;
            disp_prep[k].src0_data  = i_cdb_data[c];
          end
          if (i_disp_row[k].src1_preg == i_cdb_preg[c]) begin
            disp_prep[k].src1_ready = 1'b1;
            disp_prep[k].src1_data  = i_cdb_data[c];
          end
        end
      end
    end
  end

  // Slot-ordered allocation into the lowest free entries; entries being
  // issued this cycle still count as occupied.
  always_comb begin
    taken     = in_use;
    alloc_en  = '0;
    alloc_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      found = 1'b0;
      if (i_disp_valid[k] && o_disp_ready && !i_flush) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (!found && !taken[e]) begin
            found        = 1'b1;
            alloc_idx[k] = IW'(e);
          end
        end
        if (found) begin
          alloc_en[k]         = 1'b1;
          taken[alloc_idx[k]] = 1'b1;
        end
      end
    end
  end

  // Eligibility per FU uses start-of-cycle readiness; a flush blocks issue.
  always_comb begin
    elig = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int e = 0; e < DEPTH; e++) begin
        elig[f][e] = in_use[e] && entries[e].src0_ready && entries[e].src1_ready &&
                     (entries[e].fu == fu_idx'(f)) && i_fu_ready[f] && !i_flush;
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    rs_select #(.DEPTH(DEPTH)) u_sel (
      .elig  (elig[f]),
`ifdef RS_OLDEST_FIRST_EN
      .older (older),
`endif
      .grant (grant[f])
    );
  end

  // Mux the granted rows out and collect the set of entries leaving.
  always_comb begin
    issue_sel  = '0;
    issue_mask = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      issue_mask = issue_mask | grant[f];
      for (int e = 0; e < DEPTH; e++) begin
        if (grant[f][e]) issue_sel[f] = entries[e];
      end
    end
  end

  // Next station contents: wakeup, release of issued entries, allocation,
  // and finally a flush wiping all occupancy.
  always_comb begin
    entries_next = entries;
    in_use_next  = in_use & ~issue_mask;
    for (int e = 0; e < DEPTH; e++) begin
      for (int c = 0; c < CDB_W; c++) begin
        if (i_cdb_valid[c] && i_cdb_preg[c] != '0) begin
          if (!entries[e].src0_ready && entries[e].src0_preg == i_cdb_preg[c]) begin
            entries_next[e].src0_ready = 1'b1;
            entries_next[e].src0_data  = i_cdb_data[c];
          end
          if (!entries[e].src1_ready && entries[e].src1_preg == i_cdb_preg[c]) begin
            entries_next[e].src1_ready = 1'b1;
            entries_next[e].src1_data  = i_cdb_data[c];
          end
        end
      end
    end
    for (int k = 0; k < DISP_W; k++) begin
      if (alloc_en[k]) begin
        in_use_next[alloc_idx[k]]  = 1'b1;
        entries_next[alloc_idx[k]] = disp_prep[k];
      end
    end
    if (i_flush) in_use_next = '0;
  end

  // Occupancy count follows the next-state in-use vector.
  always_comb begin
    count_next = '0;
    for (int e = 0; e < DEPTH; e++) count_next = count_next + CW'(in_use_next[e]);
  end

  // State and issue-output registers; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_use        <= '0;
      count         <= '0;
      o_issue_valid <= '0;
      o_issue_row   <= '0;
    end else begin
      in_use  <= in_use_next;
      entries <= entries_next;
      count   <= count_next;
      for (int f = 0; f < NUM_FU; f++) begin
        o_issue_valid[f] <= |grant[f];
        o_issue_row[f]   <= issue_sel[f];
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // A newly allocated entry becomes younger than every other entry; later
  // slots are applied after earlier ones so slot 0 ends up older.
  always_comb begin
    older_next = older;
    for (int k = 0; k < DISP_W; k++) begin
      if (alloc_en[k]) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_next[alloc_idx[k]][j] = 1'b0;
          older_next[j][alloc_idx[k]] = (IW'(j) != alloc_idx[k]);
        end
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge i_clk) begin
    if (i_rst) older <= '0;
    else       older <= older_next;
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (default parameters).
// Expected results are hand-derived; the oldest-first case follows the
// RS_OLDEST_FIRST_EN build macro.
module tb_reservation_station;
  import Types::*;

  localparam int DEPTH  = 16;
  localparam int DISP_W = 2;
  localparam int NUM_FU = 3;
  localparam int CDB_W  = 3;

  logic                        i_clk = 1'b0;
  logic                        i_rst, i_flush;
  logic [DISP_W-1:0]           i_disp_valid;
  rs_row_struct [DISP_W-1:0]   i_disp_row;
  logic                        o_disp_ready;
  logic [CDB_W-1:0]            i_cdb_valid;
  p_reg [CDB_W-1:0]            i_cdb_preg;
  word [CDB_W-1:0]             i_cdb_data;
  logic [NUM_FU-1:0]           i_fu_ready;
  logic [NUM_FU-1:0]           o_issue_valid;
  rs_row_struct [NUM_FU-1:0]   o_issue_row;
  logic [$clog2(DEPTH):0]      o_count;

  int checks = 0;
  int errors = 0;

  rs_row_struct r_a, r_b, exp_row;
  p_reg         exp_dst;

  reservation_station #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_FU(NUM_FU), .CDB_W(CDB_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_flush),
    .i_disp_valid  (i_disp_valid),
    .i_disp_row    (i_disp_row),
    .o_disp_ready  (o_disp_ready),
    .i_cdb_valid   (i_cdb_valid),
    .i_cdb_preg    (i_cdb_preg),
    .i_cdb_data    (i_cdb_data),
    .i_fu_ready    (i_fu_ready),
    .o_issue_valid (o_issue_valid),
    .o_issue_row   (o_issue_row),
    .o_count       (o_count)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  function automatic rs_row_struct make_row(op_e op, fu_idx fu, p_reg dst,
                                            p_reg s0p, logic s0r, word s0d,
                                            p_reg s1p, logic s1r, word s1d);
    rs_row_struct r;
    r.op = op; r.fu = fu; r.dst = dst;
    r.src0_preg = s0p; r.src0_ready = s0r; r.src0_data = s0d;
    r.src1_preg = s1p; r.src1_ready = s1r; r.src1_data = s1d;
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [DISP_W-1:0] valid,
                                input rs_row_struct row0, input rs_row_struct row1);
    i_disp_valid  = valid;
    i_disp_row[0] = row0;
    i_disp_row[1] = row1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Linear sequence of directed steps.
  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_cdb_valid = '0; i_cdb_preg = '0;
    i_cdb_data = '0; i_fu_ready = '0;
    apply_stimulus('0, '0, '0);
    tick(); tick();
    i_rst = 1'b0;
    check_output("reset_count", 128'(o_count), 128'(0));
    check_output("reset_ready", 128'(o_disp_ready), 128'(1));
    check_output("reset_issue_valid", 128'(o_issue_valid), 128'(0));
    check_output("reset_issue_row", 128'(o_issue_row), 128'(0));

    $display("[TB] basic add issue");
    i_fu_ready = 3'b111;
    r_a = make_row(OP_ADD, FU_ALU0, 6'd1, 6'd5, 1'b1, 32'h5, 6'd6, 1'b1, 32'h6);
    apply_stimulus(2'b01, r_a, '0);
    tick();
    apply_stimulus('0, '0, '0);
    check_output("add_count_alloc", 128'(o_count), 128'(1));
    check_output("add_no_early_issue", 128'(o_issue_valid), 128'(0));
    tick();
    check_output("add_issue_valid", 128'(o_issue_valid), 128'(3'b001));
    check_output("add_issue_row", 128'(o_issue_row[0]), 128'(r_a));
    check_output("add_count_free", 128'(o_count), 128'(0));
    tick();
    check_output("add_pulse_end", 128'(o_issue_valid), 128'(0));
    check_output("add_row_zero", 128'(o_issue_row), 128'(0));

    $display("[TB] cdb wakeup");
    r_a = make_row(OP_SUB, FU_ALU1, 6'd10, 6'd9, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
    apply_stimulus(2'b01, r_a, '0);
    tick();
    apply_stimulus('0, '0, '0);
    tick(); tick();
    check_output("wake_waiting", 128'(o_issue_valid), 128'(0));
    i_cdb_valid = 3'b001; i_cdb_preg[0] = 6'd9; i_cdb_data[0] = 32'hDEADBEEF;
    tick();
    i_cdb_valid = '0;
    check_output("wake_not_yet", 128'(o_issue_valid), 128'(0));
    tick();
    exp_row = make_row(OP_SUB, FU_ALU1, 6'd10, 6'd9, 1'b1, 32'hDEADBEEF, 6'd0, 1'b1, 32'h0);
    check_output("wake_issue_valid", 128'(o_issue_valid), 128'(3'b010));
    check_output("wake_src0_data", 128'(o_issue_row[1].src0_data), 128'(32'hDEADBEEF));
    check_output("wake_issue_row", 128'(o_issue_row[1]), 128'(exp_row));

    $display("[TB] dispatch bypass");
    r_a = make_row(OP_AND, FU_ALU0, 6'd13, 6'd12, 1'b0, 32'h0, 6'd3, 1'b1, 32'h7);
    apply_stimulus(2'b01, r_a, '0);
    i_cdb_valid = 3'b010; i_cdb_preg[1] = 6'd12; i_cdb_data[1] = 32'h1234;
    tick();
    apply_stimulus('0, '0, '0);
    i_cdb_valid = '0;
    check_output("bypass_count", 128'(o_count), 128'(1));
    tick();
    exp_row = make_row(OP_AND, FU_ALU0, 6'd13, 6'd12, 1'b1, 32'h1234, 6'd3, 1'b1, 32'h7);
    check_output("bypass_issue_valid", 128'(o_issue_valid), 128'(3'b001));
    check_output("bypass_issue_row", 128'(o_issue_row[0]), 128'(exp_row));

    $display("[TB] selection order");
    i_fu_ready = '0;
    apply_stimulus(2'b11, make_row(OP_OR, FU_ALU1, 6'd40, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0),
                          make_row(OP_OR, FU_ALU1, 6'd41, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0));
    tick();
    apply_stimulus(2'b11, make_row(OP_OR, FU_ALU1, 6'd42, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0),
                          make_row(OP_ADD, FU_ALU0, 6'd43, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0));
    tick();
    apply_stimulus(2'b11, make_row(OP_OR, FU_ALU1, 6'd44, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0),
                          make_row(OP_OR, FU_ALU1, 6'd45, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0));
    tick();
    apply_stimulus(2'b11, make_row(OP_OR, FU_ALU1, 6'd46, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0),
                          make_row(OP_LD, FU_MEM, 6'd47, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0));
    tick();
    apply_stimulus('0, '0, '0);
    check_output("order_count8", 128'(o_count), 128'(8));
    i_fu_ready = 3'b001;
    tick();
    i_fu_ready = '0;
    check_output("order_e3_valid", 128'(o_issue_valid), 128'(3'b001));
    check_output("order_e3_dst", 128'(o_issue_row[0].dst), 128'(6'd43));
    apply_stimulus(2'b01, make_row(OP_ST, FU_MEM, 6'd48, 6'd0, 1'b1, 0, 6'd0, 1'b1, 0), '0);
    tick();
    apply_stimulus('0, '0, '0);
    i_fu_ready = 3'b100;
    tick();
`ifdef RS_OLDEST_FIRST_EN
    exp_dst = 6'd47;
`else
    exp_dst = 6'd48;
`endif
    check_output("order_mem_valid", 128'(o_issue_valid), 128'(3'b100));
    check_output("order_mem_dst", 128'(o_issue_row[2].dst), 128'(exp_dst));
    i_fu_ready = 3'b111;
    for (int i = 0; i < 8; i++) tick();
    check_output("order_drained", 128'(o_count), 128'(0));

    $display("[TB] full station");
    i_fu_ready = '0;
    r_a = make_row(OP_ADD, FU_ALU0, 6'd20, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
    r_b = make_row(OP_ADD, FU_ALU0, 6'd21, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 32'h4);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(2'b11, r_a, r_b);
      tick();
    end
    check_output("full_count14", 128'(o_count), 128'(14));
    check_output("full_ready14", 128'(o_disp_ready), 128'(1));
    apply_stimulus(2'b01, r_a, '0);
    tick();
    check_output("full_count15", 128'(o_count), 128'(15));
    check_output("full_not_ready", 128'(o_disp_ready), 128'(0));
    apply_stimulus(2'b11, r_a, r_b);
    tick();
    apply_stimulus('0, '0, '0);
    check_output("full_dispatch_ignored", 128'(o_count), 128'(15));
    i_fu_ready = 3'b001;
    tick();
    i_fu_ready = '0;
    check_output("full_one_issue", 128'(o_issue_valid), 128'(3'b001));
    check_output("full_count_after", 128'(o_count), 128'(14));
    check_output("full_ready_again", 128'(o_disp_ready), 128'(1));

    $display("[TB] flush and reset");
    i_fu_ready = 3'b001;
    for (int i = 0; i < 4; i++) tick();
    i_fu_ready = '0;
    tick();
    check_output("flush_pre_count", 128'(o_count), 128'(10));
    i_flush = 1'b1; i_fu_ready = 3'b111;
    apply_stimulus(2'b11, r_a, r_b);
    tick();
    i_flush = 1'b0;
    apply_stimulus('0, '0, '0);
    check_output("flush_count", 128'(o_count), 128'(0));
    check_output("flush_no_issue", 128'(o_issue_valid), 128'(0));
    check_output("flush_ready", 128'(o_disp_ready), 128'(1));
    tick();
    check_output("flush_still_empty", 128'(o_count), 128'(0));
    check_output("flush_quiet", 128'(o_issue_valid), 128'(0));
    i_fu_ready = '0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(2'b11, r_a, r_b);
      tick();
    end
    check_output("rst_pre_count", 128'(o_count), 128'(10));
    i_rst = 1'b1; i_fu_ready = 3'b111;
    tick();
    i_rst = 1'b0;
    apply_stimulus('0, '0, '0);
    check_output("rst_count", 128'(o_count), 128'(0));
    check_output("rst_no_issue", 128'(o_issue_valid), 128'(0));
    check_output("rst_row_zero", 128'(o_issue_row), 128'(0));
    check_output("rst_ready", 128'(o_disp_ready), 128'(1));
    tick();
    check_output("rst_quiet", 128'(o_issue_valid), 128'(0));
    check_output("rst_still_empty", 128'(o_count), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of station entries (power of two, >= DISP_W).
REQ-002 SHALL have parameter DISP_W, default 2, number of dispatch slots per cycle.
REQ-003 SHALL have parameter NUM_FU, default 3, number of issue ports, one per functional unit.
REQ-004 SHALL have parameter CDB_W, default 3, number of completion broadcast channels.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_flush, input, 1, discards all entries.
REQ-008 SHALL have port i_disp_valid, input, [DISP_W], dispatch request per slot.
REQ-009 SHALL have port i_disp_row, input, rs_row_struct [DISP_W], decoded and renamed operation per slot.
REQ-010 SHALL have port o_disp_ready, output, 1, at least DISP_W entries are free.
REQ-011 SHALL have port i_cdb_valid, input, [CDB_W], completion broadcast valid.
REQ-012 SHALL have port i_cdb_preg, input, p_reg [CDB_W], destination physical register being completed.
REQ-013 SHALL have port i_cdb_data, input, word [CDB_W], completed value.
REQ-014 SHALL have port i_fu_ready, input, [NUM_FU], FU accepts an operation this cycle.
REQ-015 SHALL have port o_issue_valid, output, [NUM_FU], registered one-cycle issue pulse.
REQ-016 SHALL have port o_issue_row, output, rs_row_struct [NUM_FU], issued operation with captured operands.
REQ-017 SHALL have port o_count, output, $clog2(DEPTH)+1 bits, occupied entries.

Function
REQ-018 SHALL accept a slot when i_disp_valid[k]=1, o_disp_ready=1 and i_flush=0, otherwise discard the slot; o_disp_ready derives from start-of-cycle occupancy only.
REQ-019 SHALL allocate accepted slots to the lowest-indexed free entries, slot 0 taking the lower index; an entry freed by issue this cycle is not reusable until the next cycle.
REQ-020 SHALL mark a source ready at allocation when its preg is 0 or the dispatcher flags it ready.
REQ-021 SHALL capture data and set ready for a source when any i_cdb_valid channel matches its preg in the same cycle the row is dispatched (dispatch bypass).
REQ-022 SHALL wake each not-ready resident source whose preg equals a valid i_cdb_preg, capturing i_cdb_data; preg 0 never matches.
REQ-023 SHALL consider an entry eligible for FU f when it is in use, both sources ready at start of cycle, and its fu field equals f.
REQ-024 SHALL, per FU with i_fu_ready[f]=1, select at most one eligible entry, free it, and present it on o_issue_row[f] with o_issue_valid[f]=1 for exactly the following cycle.
REQ-025 SHALL hold o_issue_valid[f]=0 and o_issue_row[f] all-zero in any cycle without an issue.
REQ-026 SHALL give minimum dispatch-to-issue latency of 2 cycles (allocate edge, select edge).
REQ-027 SHALL, on i_flush, clear all entries, drop same-cycle dispatch, suppress selection, and drive o_issue_valid=0 next cycle.
REQ-028 SHALL keep o_count equal to occupied entries after each edge, saturating neither high nor low.

Reset
REQ-029 SHALL, on i_rst sampled high, clear all in-use bits, age state and output registers: o_issue_valid=0, o_issue_row=0, o_count=0, o_disp_ready=1; i_rst mid-operation behaves as i_flush and takes priority over all other inputs.

Configuration
REQ-030 SHALL, with RS_OLDEST_FIRST_EN defined, select per FU the oldest eligible entry via an age matrix updated on allocation (slot 0 older than slot 1).
REQ-031 SHALL, without RS_OLDEST_FIRST_EN, select per FU the lowest-indexed eligible entry and omit age storage.

Structure
REQ-032 SHALL take rs_row_struct, p_reg, word and FU index constants (FU_ALU0, FU_ALU1, FU_MEM) from the shared package Types.
REQ-033 SHALL implement per-FU selection in one sub-module rs_select (eligibility vector in, one-hot grant out).

Verification
REQ-034 SHALL cover: dispatch ADD src p5,p6 ready, FU0 ready -> o_issue_valid[0] two cycles later, operands match.
REQ-035 SHALL cover: dispatch entry waiting p9, CDB p9=0xDEADBEEF three cycles later -> issue next-next cycle with src0=0xDEADBEEF.
REQ-036 SHALL cover: dispatch with src p12 while CDB broadcasts p12=0x1234 same cycle -> entry ready, issues without further broadcast.
REQ-037 SHALL cover: fill to DEPTH-1 entries -> o_disp_ready=0; dispatch ignored; one issue -> o_disp_ready=1 following cycle.
REQ-038 SHALL cover: two eligible FU2 entries, indices 7 (older) and 3 -> index 7 issues with RS_OLDEST_FIRST_EN, index 3 without.
REQ-039 SHALL cover: i_flush with 10 entries and concurrent dispatch -> o_count=0, no issue next cycle; repeat with i_rst.
